dldo_lock_supervisor: RTL and testbench

DLDO_LOCK_SUPERVISOR -- requirements
Module: dldo_lock_supervisor

---
 rtl/dldo_lock_supervisor.sv | 203 ++++++++++++++++++++
 tb/tb_dldo_lock_supervisor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dldo_lock_supervisor.sv
`default_nettype none
// =============================================================================
// Module   : dldo_lock_supervisor
// Brief    : Reset/acquire/lock/fault supervisor for a digital LDO SAR/linear FSM.
//            Define DLDO_SUP_RETRY_EN to retry timed-out acquisitions through HOLD.
// Revision : 1.0 - initial release
// =============================================================================
module dldo_lock_supervisor #(
   parameter int unsigned RST_CYC     = 8,
   parameter int unsigned LOCK_CYC    = 16,
   parameter int unsigned LOSS_CYC    = 4,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        CLKD,
   input  logic        RSTB,
   input  logic        EN,
   input  logic        INDZ,
   input  logic        CFG_WE,
   input  logic [13:0] CFG_LINTH,
   input  logic [7:0]  CFG_MAXSTEP,
   output logic        FSM_RST,
   output logic [13:0] LINTH,
   output logic [7:0]  MAXSTEPSIZE,
   output logic        LOCKED,
   output logic        FAULT,
   output logic [2:0]  STATE,
   output logic [1:0]  RETRY_CNT
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HOLD  = 3'd1,
      S_ACQ   = 3'd2,
      S_LOCK  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   localparam int c_HOLD_W  = $clog2(RST_CYC + 1);
   localparam int c_DWELL_W = $clog2(LOCK_CYC + 1);
   localparam int c_LOSS_W  = $clog2(LOSS_CYC + 1);
   localparam int c_TRY_W   = ($clog2(MAX_RETRY + 2) < 2) ? 2 : $clog2(MAX_RETRY + 2);

   localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(RST_CYC - 1);
   localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(LOCK_CYC - 1);
   localparam logic [c_LOSS_W-1:0]  c_LOSS_LAST  = c_LOSS_W'(LOSS_CYC - 1);
   localparam logic [10:0]          c_TIMER_LAST = 11'(TIMEOUT_CYC - 1);
`ifdef DLDO_SUP_RETRY_EN
   localparam logic [c_TRY_W-1:0]   c_RETRY_LIMIT = c_TRY_W'(MAX_RETRY);
`else
   localparam logic [c_TRY_W-1:0]   c_RETRY_LIMIT = '0;
`endif
   localparam logic [13:0]          c_LINTH_RST  = 14'h0100;
   localparam logic [7:0]           c_STEP_RST   = 8'd8;

   state_t               state_q, state_d;
   logic [c_HOLD_W-1:0]  hold_q, hold_d;
   logic [c_DWELL_W-1:0] dwell_q, dwell_d;
   logic [c_LOSS_W-1:0]  loss_q, loss_d;
   logic [10:0]          timer_q, timer_d;
   logic [c_TRY_W-1:0]   tries_q, tries_d;
   logic [13:0]          plin_q, plin_d;
   logic [7:0]           pstep_q, pstep_d;
   logic [13:0]          linth_q, linth_d;
   logic [7:0]           step_q, step_d;
   logic                 fsm_rst_q, locked_q, fault_q;
   logic                 w_apply;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      dwell_d = dwell_q;
      loss_d  = loss_q;
      timer_d = timer_q;
      tries_d = tries_q;
      plin_d  = plin_q;
      pstep_d = pstep_q;
      linth_d = linth_q;
      step_d  = step_q;

      if (CFG_WE) begin
         plin_d  = CFG_LINTH;
         pstep_d = (CFG_MAXSTEP == 8'd0) ? 8'd1 : CFG_MAXSTEP;
      end

      if (!EN) begin
         state_d = S_IDLE;
         hold_d  = '0;
         dwell_d = '0;
         loss_d  = '0;
         timer_d = '0;
         tries_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_HOLD;
               hold_d  = '0;
            end
            S_HOLD: begin
               if (hold_q == c_HOLD_LAST) begin
                  state_d = S_ACQ;
                  timer_d = '0;
                  dwell_d = '0;
               end else begin
                  hold_d = (hold_q == '1) ? hold_q : hold_q + c_HOLD_W'(1);
               end
            end
            S_ACQ: begin
               timer_d = (timer_q == '1) ? timer_q : timer_q + 11'd1;
               dwell_d = !INDZ ? '0 : ((dwell_q == '1) ? dwell_q : dwell_q + c_DWELL_W'(1));
               // Lock wins if it completes on the same cycle the attempt expires.
               if (INDZ && (dwell_q == c_DWELL_LAST)) begin
                  state_d = S_LOCK;
                  loss_d  = '0;
                  tries_d = '0;
               end else if (timer_q == c_TIMER_LAST) begin
                  tries_d = (tries_q == '1) ? tries_q : tries_q + c_TRY_W'(1);
                  if (tries_d > c_RETRY_LIMIT) begin
                     state_d = S_FAULT;
                  end else begin
                     state_d = S_HOLD;
                     hold_d  = '0;
                  end
               end
            end
            S_LOCK: begin
               loss_d = INDZ ? '0 : ((loss_q == '1) ? loss_q : loss_q + c_LOSS_W'(1));
               // Loss of lock re-acquires without resetting the regulator FSM.
               if (!INDZ && (loss_q == c_LOSS_LAST)) begin
                  state_d = S_ACQ;
                  timer_d = '0;
                  dwell_d = '0;
               end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
         endcase
      end

      // Applied config moves only while idle or on the edge that enters HOLD.
      w_apply = (state_q == S_IDLE) || ((state_d == S_HOLD) && (state_q != S_HOLD));
      if (w_apply) begin
         linth_d = plin_d;
         step_d  = pstep_d;
      end
   end

`ifdef DLDO_SUP_RETRY_EN
   logic [1:0] retry_q;
`endif

   always_ff @(posedge CLKD or negedge RSTB) begin
      if (!RSTB) begin
         state_q   <= S_IDLE;
         hold_q    <= '0;
         dwell_q   <= '0;
         loss_q    <= '0;
         timer_q   <= '0;
         tries_q   <= '0;
         plin_q    <= c_LINTH_RST;
         pstep_q   <= c_STEP_RST;
         linth_q   <= c_LINTH_RST;
         step_q    <= c_STEP_RST;
         fsm_rst_q <= 1'b1;
         locked_q  <= 1'b0;
         fault_q   <= 1'b0;
`ifdef DLDO_SUP_RETRY_EN
         retry_q   <= 2'd0;
`endif
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         dwell_q   <= dwell_d;
         loss_q    <= loss_d;
         timer_q   <= timer_d;
         tries_q   <= tries_d;
         plin_q    <= plin_d;
         pstep_q   <= pstep_d;
         linth_q   <= linth_d;
         step_q    <= step_d;
         fsm_rst_q <= !((state_d == S_ACQ) || (state_d == S_LOCK));
         locked_q  <= (state_d == S_LOCK);
         fault_q   <= (state_d == S_FAULT);
`ifdef DLDO_SUP_RETRY_EN
         retry_q   <= (tries_d > c_TRY_W'(3)) ? 2'd3 : tries_d[1:0];
`endif
      end
   end

   assign FSM_RST     = fsm_rst_q;
   assign LINTH       = linth_q;
   assign MAXSTEPSIZE = step_q;
   assign LOCKED      = locked_q;
   assign FAULT       = fault_q;
   assign STATE       = state_q;
`ifdef DLDO_SUP_RETRY_EN
   assign RETRY_CNT   = retry_q;
`else
   assign RETRY_CNT   = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dldo_lock_supervisor.sv
`default_nettype none
// =============================================================================
// Module   : tb_dldo_lock_supervisor
// Brief    : Self-checking bench: directed literal checks plus randomized traffic
//            compared every cycle against a behavioural supervisor model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_dldo_lock_supervisor;

   localparam int RST_CYC = 8, LOCK_CYC = 16, LOSS_CYC = 4, TIMEOUT_CYC = 1024, MAX_RETRY = 3;
   localparam int IDLE = 0, HOLD = 1, ACQ = 2, LOCK = 3, FLT = 4;
`ifdef DLDO_SUP_RETRY_EN
   localparam bit RETRY_ON = 1'b1;
`else
   localparam bit RETRY_ON = 1'b0;
`endif

   logic        CLKD = 1'b0;
   logic        RSTB, EN, INDZ, CFG_WE;
   logic [13:0] CFG_LINTH;
   logic [7:0]  CFG_MAXSTEP;
   logic        FSM_RST, LOCKED, FAULT;
   logic [13:0] LINTH;
   logic [7:0]  MAXSTEPSIZE;
   logic [2:0]  STATE;
   logic [1:0]  RETRY_CNT;

   int n_chk = 0;
   int n_fail = 0;

   dldo_lock_supervisor dut (
      .CLKD(CLKD), .RSTB(RSTB), .EN(EN), .INDZ(INDZ), .CFG_WE(CFG_WE),
      .CFG_LINTH(CFG_LINTH), .CFG_MAXSTEP(CFG_MAXSTEP), .FSM_RST(FSM_RST),
      .LINTH(LINTH), .MAXSTEPSIZE(MAXSTEPSIZE), .LOCKED(LOCKED), .FAULT(FAULT),
      .STATE(STATE), .RETRY_CNT(RETRY_CNT)
   );

   always #5 CLKD = ~CLKD;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Behavioural model: elapsed-count bookkeeping per supervisor phase.
   int m_st, m_hold, m_dwell, m_loss, m_timer, m_tries, m_plin, m_pstep, m_lin, m_step;

   task automatic model_reset();
      m_st = IDLE; m_hold = 0; m_dwell = 0; m_loss = 0; m_timer = 0; m_tries = 0;
      m_plin = 'h100; m_pstep = 8; m_lin = 'h100; m_step = 8;
   endtask

   task automatic model_step();
      int nxt;
      nxt = m_st;
      if (CFG_WE) begin
         m_plin  = int'(CFG_LINTH);
         m_pstep = (CFG_MAXSTEP == 8'd0) ? 1 : int'(CFG_MAXSTEP);
      end
      if (!EN) begin
         nxt = IDLE; m_hold = 0; m_dwell = 0; m_loss = 0; m_timer = 0; m_tries = 0;
      end else if (m_st == IDLE) begin
         nxt = HOLD; m_hold = 0;
      end else if (m_st == HOLD) begin
         m_hold++;
         if (m_hold == RST_CYC) begin nxt = ACQ; m_timer = 0; m_dwell = 0; end
      end else if (m_st == ACQ) begin
         m_timer++;
         m_dwell = INDZ ? m_dwell + 1 : 0;
         if (m_dwell == LOCK_CYC) begin
            nxt = LOCK; m_tries = 0; m_loss = 0;
         end else if (m_timer == TIMEOUT_CYC) begin
            m_tries++;
            if (RETRY_ON && m_tries <= MAX_RETRY) begin nxt = HOLD; m_hold = 0; end
            else nxt = FLT;
         end
      end else if (m_st == LOCK) begin
         m_loss = INDZ ? 0 : m_loss + 1;
         if (m_loss == LOSS_CYC) begin nxt = ACQ; m_timer = 0; m_dwell = 0; end
      end
      if (m_st == IDLE || (nxt == HOLD && m_st != HOLD)) begin
         m_lin = m_plin; m_step = m_pstep;
      end
      m_st = nxt;
   endtask

   always @(posedge CLKD or negedge RSTB) begin
      if (!RSTB) model_reset();
      else       model_step();
   end

   always @(negedge CLKD) begin
      chk("STATE", int'(STATE), m_st);
      chk("FSM_RST", int'(FSM_RST), (m_st == ACQ || m_st == LOCK) ? 0 : 1);
      chk("LOCKED", int'(LOCKED), (m_st == LOCK) ? 1 : 0);
      chk("FAULT", int'(FAULT), (m_st == FLT) ? 1 : 0);
      chk("RETRY_CNT", int'(RETRY_CNT), RETRY_ON ? ((m_tries > 3) ? 3 : m_tries) : 0);
      chk("LINTH", int'(LINTH), m_lin);
      chk("MAXSTEPSIZE", int'(MAXSTEPSIZE), m_step);
   end

   task automatic cyc();
      @(posedge CLKD);
      @(negedge CLKD);
      #1;
   endtask

   initial begin
      int n, acq_at, mode, len;
      bit drops;
      EN = 1'b0; INDZ = 1'b0; CFG_WE = 1'b0; CFG_LINTH = '0; CFG_MAXSTEP = '0;
      RSTB = 1'b1;
      #1 RSTB = 1'b0;
      repeat (3) cyc();
      chk("rst_state", int'(STATE), 0);
      chk("rst_fsm_rst", int'(FSM_RST), 1);
      chk("rst_locked", int'(LOCKED), 0);
      chk("rst_fault", int'(FAULT), 0);
      chk("rst_retry", int'(RETRY_CNT), 0);
      chk("rst_linth", int'(LINTH), 'h100);
      chk("rst_maxstep", int'(MAXSTEPSIZE), 8);

      RSTB = 1'b1;
      cyc();
      CFG_WE = 1'b1; CFG_LINTH = 14'h0100; CFG_MAXSTEP = 8'd0;
      cyc();
      CFG_WE = 1'b0;
      chk("idle_maxstep0_to_1", int'(MAXSTEPSIZE), 1);
      chk("idle_linth", int'(LINTH), 'h100);

      // Acquisition with INDZ stuck high.
      EN = 1'b1; INDZ = 1'b1; n = 0; acq_at = 0;
      while (!LOCKED && n < 100) begin
         cyc(); n++;
         if (STATE == 3'd2 && acq_at == 0) begin
            acq_at = n;
            chk("fsm_rst_at_acq", int'(FSM_RST), 0);
         end
      end
      chk("acq_entry_cycle", acq_at, 1 + RST_CYC);
      chk("lock_cycle", n, 1 + RST_CYC + LOCK_CYC);
      chk("model_lock", m_st, LOCK);

      // Config written during LOCK must not reach the outputs.
      CFG_WE = 1'b1; CFG_LINTH = 14'h0200; CFG_MAXSTEP = 8'h20;
      cyc();
      CFG_WE = 1'b0;
      chk("lock_linth_held", int'(LINTH), 'h100);
      INDZ = 1'b0; repeat (3) cyc();
      INDZ = 1'b1; cyc();
      chk("lock_survives_3_low", int'(STATE), LOCK);
      INDZ = 1'b0; repeat (4) cyc();
      chk("loss_to_acq", int'(STATE), ACQ);
      chk("loss_fsm_rst", int'(FSM_RST), 0);
      chk("acq_linth_held", int'(LINTH), 'h100);
      EN = 1'b0; cyc();
      chk("en_low_idle", int'(STATE), IDLE);
      EN = 1'b1; cyc();
      chk("hold_entry_state", int'(STATE), HOLD);
      chk("hold_entry_linth", int'(LINTH), 'h200);
      chk("hold_entry_step", int'(MAXSTEPSIZE), 'h20);

      // Timeout path with INDZ stuck low.
      EN = 1'b0; cyc();
      EN = 1'b1; INDZ = 1'b0; n = 0;
      while (!FAULT && n < 6000) begin cyc(); n++; end
      chk("fault_cycle", n, RETRY_ON ? 1 + 4 * (RST_CYC + TIMEOUT_CYC) : 1 + RST_CYC + TIMEOUT_CYC);
      chk("fault_retry_cnt", int'(RETRY_CNT), RETRY_ON ? 3 : 0);
      chk("fault_fsm_rst", int'(FSM_RST), 1);
      repeat (5) cyc();
      chk("fault_sticky", int'(STATE), FLT);
      EN = 1'b0; cyc();
      chk("fault_exit_idle", int'(STATE), IDLE);
      chk("fault_exit_flag", int'(FAULT), 0);
      chk("fault_exit_retry", int'(RETRY_CNT), 0);

      // Randomized traffic; the per-cycle compare process does the checking.
      for (int seg = 0; seg < 14; seg++) begin
         mode  = int'($urandom_range(0, 2));
         len   = int'($urandom_range(40, 5000));
         drops = ($urandom_range(0, 1) == 0);
         for (int k = 0; k < len; k++) begin
            case (mode)
               0:       INDZ = ($urandom_range(0, 15) != 0);
               1:       INDZ = ($urandom_range(0, 7) == 0);
               default: INDZ = ($urandom_range(0, 1) == 1);
            endcase
            EN          = drops ? ($urandom_range(0, 299) != 0) : 1'b1;
            CFG_WE      = ($urandom_range(0, 19) == 0);
            CFG_LINTH   = 14'($urandom);
            CFG_MAXSTEP = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 2999) == 0) begin
               RSTB = 1'b0; cyc(); RSTB = 1'b1;
            end
            cyc();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
